// File: rtl/d_mem_lsu.sv
// d_mem_lsu: load/store initiator that splits core requests into word-aligned data-memory beats.
// Core side: req_valid/req_ready handshake with req_wr, req_size, req_signed, req_addr and req_wdata.
// The rsp_valid pulse carries rsp_rdata.
// Memory side: address, byteena, data, rden and wren are outputs; q is the read data returned 1 cycle after rden.
module d_mem_lsu (
  input  logic        clock,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [31:0] address,
  output logic [3:0]  byteena,
  output logic [31:0] data,
  output logic        rden,
  output logic        wren,
  input  logic [31:0] q
);
  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, WAIT, RESP} state_t;
  state_t      state;
  logic        wr_r, sgn_r, split_r;
  logic [1:0]  size_r, off_r;
  logic [31:0] b1_addr, b1_data, lo;
  logic [3:0]  b1_be;
  logic [3:0]  m;
  logic [7:0]  mask8;
  logic [63:0] w64;
  logic [31:0] base, rd, ext;
  function automatic logic [31:0] lanes(input logic [3:0] b);
    return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction
  always_comb begin
    m = req_size == 2'd0 ? 4'b0001 : req_size == 2'd1 ? 4'b0011 : 4'b1111;
    mask8 = {4'b0000, m} << req_addr[1:0];
    w64 = req_wr ? {32'b0, req_wdata} << {req_addr[1:0], 3'b000} : 64'b0;
    base = {req_addr[31:2], 2'b00};
    // beat-1 data is still in flight on q while WAIT runs, so the word pair is formed from q directly
    rd = 32'((split_r ? {q, lo} : {32'b0, q}) >> {off_r, 3'b000});
    ext = size_r == 2'd0 ? {{24{sgn_r & rd[7]}}, rd[7:0]} :
          size_r == 2'd1 ? {{16{sgn_r & rd[15]}}, rd[15:0]} : rd;
    req_ready = state == IDLE;
  end
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      {wr_r, sgn_r, split_r, size_r, off_r} <= '0;
      {b1_addr, b1_data, b1_be, lo} <= '0;
      {rsp_valid, rsp_rdata, address, byteena, data, rden, wren} <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          wr_r <= req_wr;
          sgn_r <= req_signed;
          size_r <= req_size;
          off_r <= req_addr[1:0];
          split_r <= |mask8[7:4];
          address <= base;
          byteena <= mask8[3:0];
          data <= w64[31:0] & lanes(mask8[3:0]);
          rden <= !req_wr;
          wren <= req_wr;
          b1_addr <= base + 32'd4;
          b1_be <= mask8[7:4];
          b1_data <= w64[63:32] & lanes(mask8[7:4]);
          state <= BEAT0;
        end
        BEAT0: if (split_r) begin
          address <= b1_addr;
          byteena <= b1_be;
          data <= b1_data;
          state <= BEAT1;
        end else begin
          {byteena, data, rden, wren} <= '0;
          state <= WAIT;
        end
        BEAT1: begin
          lo <= q;
          {byteena, data, rden, wren} <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (!split_r) lo <= q;
          rsp_valid <= 1'b1;
          rsp_rdata <= wr_r ? 32'b0 : ext;
          state <= RESP;
        end
        default: begin
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_d_mem_lsu.sv
// tb_d_mem_lsu: table-driven bench with a response scoreboard and a byte-lane memory model for d_mem_lsu.
module tb_d_mem_lsu;
  logic        clock = 0, rst = 1, req_valid = 0, req_wr = 0, req_signed = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, rsp_valid, rden, wren;
  logic [31:0] rsp_rdata, address, data, q;
  logic [3:0]  byteena;
  logic [31:0] mem [0:255];
  int tests = 0, fails = 0;
  logic [31:0] sb [$];
  typedef struct {
    logic wr; logic [1:0] size; logic sgn; logic [31:0] addr, wdata;
    logic [31:0] a0; logic [3:0] be0; logic [31:0] d0;
    logic [31:0] a1; logic [3:0] be1; logic [31:0] d1;
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs [$];
  d_mem_lsu dut (.clock(clock), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .address(address),
    .byteena(byteena), .data(data), .rden(rden), .wren(wren), .q(q));
  always #5 clock = ~clock;
  always_ff @(posedge clock) begin
    if (rden) q <= mem[address[9:2]];
    for (int i = 0; i < 4; i++)
      if (wren && byteena[i]) mem[address[9:2]][8*i +: 8] <= data[8*i +: 8];
  end
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
      input logic [31:0] addr, wdata, a0, input logic [3:0] be0, input logic [31:0] d0,
      input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] d1, input logic [31:0] rdata);
    vec_t v;
    v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.a0 = a0; v.be0 = be0; v.d0 = d0; v.a1 = a1; v.be1 = be1; v.d1 = d1; v.rdata = rdata;
    return v;
  endfunction
  task automatic run_vec(input vec_t v);
    logic split;
    int c;
    split = v.be1 != 0;
    @(negedge clock);
    chk("ready_before", req_ready, 1'b1);
    {req_valid, req_wr, req_size, req_signed, req_addr, req_wdata} = {1'b1, v.wr, v.size, v.sgn, v.addr, v.wdata};
    sb.push_back(v.rdata);
    @(negedge clock);
    req_valid = 0;
    chk("beat0", {address, byteena, data, rden, wren, req_ready}, {v.a0, v.be0, v.d0, !v.wr, v.wr, 1'b0});
    @(negedge clock);
    if (split) chk("beat1", {address, byteena, data, rden, wren}, {v.a1, v.be1, v.d1, !v.wr, v.wr});
    else chk("quiet_after_beat0", {address, byteena, data, rden, wren}, {v.a0, 4'h0, 32'h0, 2'b00});
    c = 2;
    if (split) begin
      @(negedge clock);
      c = 3;
      chk("quiet_after_beat1", {address, byteena, data, rden, wren}, {v.a1, 4'h0, 32'h0, 2'b00});
    end
    do begin @(negedge clock); c++; end while (!rsp_valid && c < 12);
    chk("rsp_latency", c, split ? 4 : 3);
    if (rsp_valid && sb.size() > 0) chk("rsp_rdata", rsp_rdata, sb.pop_front());
    else if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clock);
    chk("idle_after_rsp", {req_ready, rsp_valid}, 2'b10);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs.push_back(mk(1, 2, 0, 32'h40, 32'h11223344, 32'h40, 4'hF, 32'h11223344, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 0, 32'h40, 32'h80FF0011, 32'h40, 4'hF, 32'h80FF0011, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h43, 0, 32'h40, 4'b1000, 0, 0, 0, 0, 32'hFFFFFF80));
    vecs.push_back(mk(0, 0, 0, 32'h43, 0, 32'h40, 4'b1000, 0, 0, 0, 0, 32'h00000080));
    vecs.push_back(mk(0, 1, 1, 32'h42, 0, 32'h40, 4'b1100, 0, 0, 0, 0, 32'hFFFF80FF));
    vecs.push_back(mk(0, 1, 0, 32'h40, 0, 32'h40, 4'b0011, 0, 0, 0, 0, 32'h00000011));
    vecs.push_back(mk(1, 0, 0, 32'h41, 32'h123456AB, 32'h40, 4'b0010, 32'h0000AB00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2, 0, 32'h40, 0, 32'h40, 4'hF, 0, 0, 0, 0, 32'h80FFAB11));
    vecs.push_back(mk(1, 1, 0, 32'h43, 32'h0000BEEF, 32'h40, 4'b1000, 32'hEF000000, 32'h44, 4'b0001, 32'h000000BE, 0));
    vecs.push_back(mk(0, 2, 0, 32'h40, 0, 32'h40, 4'hF, 0, 0, 0, 0, 32'hEFFFAB11));
    vecs.push_back(mk(0, 0, 0, 32'h44, 0, 32'h44, 4'b0001, 0, 0, 0, 0, 32'h000000BE));
    vecs.push_back(mk(1, 2, 0, 32'h40, 32'h44332211, 32'h40, 4'hF, 32'h44332211, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 0, 32'h44, 32'h88776655, 32'h44, 4'hF, 32'h88776655, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2, 0, 32'h42, 0, 32'h40, 4'b1100, 0, 32'h44, 4'b0011, 0, 32'h66554433));
    vecs.push_back(mk(0, 0, 1, 32'h47, 0, 32'h44, 4'b1000, 0, 0, 0, 0, 32'hFFFFFF88));
    vecs.push_back(mk(1, 2, 0, 32'hFFFFFFFC, 32'hDEADBEEF, 32'hFFFFFFFC, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 0, 32'h0, 32'hCAFEF00D, 32'h0, 4'hF, 32'hCAFEF00D, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2, 0, 32'hFFFFFFFE, 0, 32'hFFFFFFFC, 4'b1100, 0, 32'h0, 4'b0011, 0, 32'hF00DDEAD));
    vecs.push_back(mk(0, 1, 1, 32'h1, 0, 32'h0, 4'b0110, 0, 0, 0, 0, 32'hFFFFFEF0));
    vecs.push_back(mk(1, 3, 0, 32'h8, 32'h01020304, 32'h8, 4'hF, 32'h01020304, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3, 1, 32'h8, 0, 32'h8, 4'hF, 0, 0, 0, 0, 32'h01020304));
    repeat (2) @(negedge clock);
    chk("reset_values", {req_ready, rsp_valid, rsp_rdata, address, byteena, data, rden, wren},
        {1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 2'b00});
    rst = 0;
    foreach (vecs[i]) run_vec(vecs[i]);
    // held req_valid with three aligned word loads: accepts every 4 cycles
    for (int t = 0; t < 12; t++) begin
      @(negedge clock);
      chk("b2b_ready", req_ready, t % 4 == 0);
      chk("b2b_rsp_valid", rsp_valid, t % 4 == 3);
      if (rsp_valid && sb.size() > 0) chk("b2b_rdata", rsp_rdata, sb.pop_front());
      if (t == 0) begin
        {req_valid, req_wr, req_size, req_signed, req_addr} = {1'b1, 1'b0, 2'd2, 1'b0, 32'h40};
        sb.push_back(32'h44332211);
      end
      if (t == 4) begin req_addr = 32'h44; sb.push_back(32'h88776655); end
      if (t == 8) begin req_addr = 32'h8; sb.push_back(32'h01020304); end
      if (t == 9) req_valid = 0;
    end
    chk("b2b_queue_empty", sb.size(), 0);
    // reset during beat 0 of a split store
    @(negedge clock);
    {req_valid, req_wr, req_size, req_signed, req_addr, req_wdata} = {1'b1, 1'b1, 2'd2, 1'b0, 32'h42, 32'hA5A5A5A5};
    @(negedge clock);
    req_valid = 0;
    chk("rst_beat0_wren", {wren, byteena}, {1'b1, 4'b1100});
    #2 rst = 1;
    #1 chk("rst_async", {wren, rden, byteena, data, req_ready, rsp_valid}, {2'b00, 4'h0, 32'h0, 1'b1, 1'b0});
    @(negedge clock);
    rst = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clock);
      chk("rst_quiet", {wren, rden, rsp_valid, req_ready}, 4'b0001);
    end
    chk("rst_mem44", mem[8'h11], 32'h88776655);
    chk("rst_mem40", mem[8'h10], 32'h44332211);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/d_mem_lsu.md
# d_mem_lsu

- Core-side load/store initiator that drives the data-memory access port: `address`, `byteena`, `data`, `rden`, `wren` out, `q` in, with 1-cycle registered read latency.
- Converts a core request (address, size, signedness, store data) into one or two word-aligned memory beats:
  - builds byte enables;
  - lane-shifts store data;
  - splits accesses that cross a word boundary;
  - reassembles and sign/zero-extends load data.
- Sits between the core pipeline's memory stage and the data memory, one instance per core.

## Interface
- Parameters: none. Fixed widths: 32-bit address/data, 4 byte lanes, memory read latency 1 cycle.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clock`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  core request present.
- `req_ready`  out  1  block idle, request accepted this cycle if `req_valid`.
- `req_wr`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 byte, 1 half, 2 word, 3 treated as word.
- `req_signed`  in  1  loads: sign-extend (1) / zero-extend (0); ignored for stores.
- `req_addr`  in  32  byte address, any alignment.
- `req_wdata`  in  32  store data, right-justified.
- `rsp_valid`  out  1  one-cycle pulse: load data valid / store complete.
- `rsp_rdata`  out  32  extended load data; 0 for stores.
- `address`  out  32  word-aligned memory address.
- `byteena`  out  4  active byte lanes.
- `data`  out  32  lane-aligned store data; inactive lanes 0.
- `rden`  out  1  memory read strobe.
- `wren`  out  1  memory write strobe.
- `q`  in  32  memory read data, valid the cycle after `rden`.

## Operation
- States: IDLE, BEAT0, BEAT1, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, capture the request and the beat-0/beat-1 memory fields into registers; go to BEAT0.
- Beat fields, with off = `req_addr[1:0]` and m = 4'b0001/4'b0011/4'b1111 for size 0/1/2(3):
  - mask8 = m << off, 8 bits.
  - Beat 0: `address` = {`req_addr[31:2]`,2'b00}, `byteena` = mask8[3:0].
  - Beat 1: `address` = beat-0 address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000); `byteena` = mask8[7:4].
  - Split when mask8[7:4] != 0.
- Store data: w64 = {32'b0,`req_wdata`} << 8·off. Beat 0 `data` = w64[31:0], beat 1 `data` = w64[63:32]. Lanes not in `byteena` are forced to 0.
- BEAT0:
  - Drive beat-0 fields with `rden`=!wr and `wren`=wr.
  - Next state is BEAT1 if split, else WAIT.
- BEAT1:
  - Drive beat-1 fields.
  - Capture `q` (beat-0 read data) into lo.
  - Next state: WAIT.
- WAIT:
  - No strobes.
  - Capture `q` into hi if split, else into lo.
  - Next state: RESP.
- RESP:
  - `rsp_valid`=1 for exactly one cycle.
  - `rsp_rdata` = extend(({hi,lo} >> 8·off), size, signed) for loads; 0 for stores.
  - Next state: IDLE.
- Extension: take the low 1/2/4 bytes. Sign bit is bit 7/15/31 when `req_signed`=1; otherwise zero-fill.
- Outputs: all memory-side outputs and `rsp_*` are registered. Outside BEAT0/BEAT1, `rden`/`wren`/`byteena`/`data` are 0 and `address` holds its last value.

## Timing
- T0: request accepted in IDLE.
- Non-split request:
  - T1: BEAT0 strobes.
  - T2: `q` sampled.
  - T3: `rsp_valid`.
  - T4: `req_ready` back to 1.
- Split request:
  - T1: beat 0.
  - T2: beat 1 (beat-0 `q` sampled).
  - T3: beat-1 `q` sampled.
  - T4: `rsp_valid`.
  - T5: `req_ready`.
- `req_ready` is 0 in every non-IDLE state.
- Request inputs are don't-care after acceptance.
- No request is lost when `req_valid` is held high: the next request is accepted on the first IDLE cycle.
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `address`=0, `byteena`=0, `data`=0, `rden`=0, `wren`=0, state IDLE.
- Reset mid-operation:
  - `rst` forces IDLE and all reset values immediately, with no clock needed; strobes drop in the same cycle.
  - The in-flight request is dropped with no `rsp_valid`.
  - A beat 1 not yet issued is never issued.
- `rden` and `wren` are never both 1.

## Test plan
- Aligned store: SW 0x11223344 @0x40.
  - T1: `address`=0x40, `byteena`=4'b1111, `data`=0x11223344, `wren`=1, `rden`=0.
  - T3: `rsp_valid`=1, `rsp_rdata`=0.
- Byte loads, mem[0x40]=0x80FF0011:
  - LB @0x43 → `byteena`=4'b1000, `rsp_rdata`=0xFFFFFF80.
  - LBU @0x43 → 0x00000080.
  - LH @0x42 → 0xFFFF80FF.
- Split store: SH 0x0000BEEF @0x43.
  - T1: 0x40 / 4'b1000 / 0xEF000000.
  - T2: 0x44 / 4'b0001 / 0x000000BE.
  - T4: `rsp_valid`.
- Split load: mem[0x40]=0x44332211, mem[0x44]=0x88776655.
  - LW @0x42 → T1 `rden` 0x40 / 4'b1100, T2 `rden` 0x44 / 4'b0011, T4 `rsp_rdata`=0x66554433.
  - LW @0xFFFFFFFE → beat-1 `address`=0x00000000.
- Back-to-back: `req_valid` held high with three aligned LWs.
  - `req_ready` is 1 only at T0, T4, T8.
  - `rsp_valid` pulses at T3, T7, T11 with the correct data.
- Reset mid-op: assert `rst` during BEAT0 of a split SW.
  - `wren`=0 and `byteena`=0 before the next edge; no beat 1, no `rsp_valid`; memory at 0x44 unchanged.
  - After release, `req_ready`=1.
